// File: rtl/lock_access_controller.sv
// Keypad front-end for the electronic-lock core: debounces raw codes into single
// key events, tracks 4-digit attempts, and enforces a lockout after repeated failures.
module lock_access_controller #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int VERIFY_CYCLES   = 8,
   parameter int MAX_FAILS       = 3,
   parameter int LOCKOUT_CYCLES  = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] key_raw,
   input  logic       unlocked_in,
   output logic [3:0] key_out,
   output logic       key_stb,
   output logic       lockout,
   output logic [2:0] fail_count,
   output logic [2:0] digit_count
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int VW = $clog2(VERIFY_CYCLES) + 1;
   localparam int LW = $clog2(LOCKOUT_CYCLES) + 1;

   localparam logic [3:0]    KEY_IDLE   = 4'hF;
   localparam logic [3:0]    KEY_SET    = 4'hE;
   localparam logic [3:0]    KEY_CANCEL = 4'hD;
   localparam logic [DW-1:0] DEB_MAX    = DW'(DEBOUNCE_CYCLES);
   localparam logic [VW-1:0] VER_LAST   = VW'(VERIFY_CYCLES - 1);
   localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCKOUT_CYCLES - 1);
   localparam logic [2:0]    FAIL_MAX   = 3'(MAX_FAILS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ENTRY,
      S_VERIFY,
      S_CANCEL,
      S_LOCKOUT
   } state_t;

   state_t        state_q, state_d;
   logic [3:0]    prev_q, prev_d;
   logic [DW-1:0] cnt_q, cnt_d;
   logic          armed_q, armed_d;
   logic [3:0]    key_out_q, key_out_d;
   logic          key_stb_q, key_stb_d;
   logic          lockout_q, lockout_d;
   logic [2:0]    fail_q, fail_d;
   logic [2:0]    dig_q, dig_d;
   logic [VW-1:0] vt_q, vt_d;
   logic [LW-1:0] lt_q, lt_d;

   logic       stable;
   logic       evt;
   logic       is_digit;

   // Debounce: cnt_q holds the run length of prev_q, saturating at DEB_MAX.
   always_comb begin
      prev_d  = key_raw;
      cnt_d   = cnt_q;
      armed_d = armed_q;
      if (key_raw != prev_q) begin
         cnt_d = DW'(1);
      end else if (cnt_q != DEB_MAX) begin
         cnt_d = cnt_q + DW'(1);
      end
      stable = (cnt_q == DEB_MAX);
      evt    = stable && (prev_q != KEY_IDLE) && armed_q;
      // Every matured press disarms, even when the FSM discards it.
      if (stable && (prev_q == KEY_IDLE)) begin
         armed_d = 1'b1;
      end else if (evt) begin
         armed_d = 1'b0;
      end
   end

   assign is_digit = (prev_q >= 4'd1) && (prev_q <= 4'd9);

   always_comb begin
      state_d   = state_q;
      key_out_d = KEY_IDLE;
      key_stb_d = 1'b0;
      fail_d    = fail_q;
      dig_d     = dig_q;
      vt_d      = vt_q;
      lt_d      = lt_q;
      unique case (state_q)
         S_IDLE: begin
            if (evt) begin
               if (is_digit) begin
                  key_out_d = prev_q;
                  key_stb_d = 1'b1;
                  dig_d     = 3'd1;
                  state_d   = S_ENTRY;
               end else if ((prev_q == KEY_SET) || (prev_q == KEY_CANCEL)) begin
                  key_out_d = prev_q;
                  key_stb_d = 1'b1;
               end
            end
         end
         S_ENTRY: begin
            // Set-passcode mid-attempt has no meaning to the core and is dropped.
            if (evt) begin
               if (is_digit) begin
                  key_out_d = prev_q;
                  key_stb_d = 1'b1;
                  dig_d     = dig_q + 3'd1;
                  if (dig_q == 3'd3) begin
                     state_d = S_VERIFY;
                     vt_d    = '0;
                  end
               end else if (prev_q == KEY_CANCEL) begin
                  key_out_d = prev_q;
                  key_stb_d = 1'b1;
                  dig_d     = 3'd0;
                  state_d   = S_IDLE;
               end
            end
         end
         S_VERIFY: begin
            // Unlock is checked before expiry so a last-cycle unlock still succeeds.
            if (unlocked_in) begin
               fail_d  = 3'd0;
               dig_d   = 3'd0;
               state_d = S_IDLE;
            end else if (vt_q == VER_LAST) begin
               fail_d    = (fail_q >= FAIL_MAX) ? FAIL_MAX : fail_q + 3'd1;
               dig_d     = 3'd0;
               key_out_d = KEY_CANCEL;
               key_stb_d = 1'b1;
               state_d   = S_CANCEL;
            end else begin
               vt_d = vt_q + VW'(1);
            end
         end
         S_CANCEL: begin
            if (fail_q == FAIL_MAX) begin
               lt_d    = '0;
               state_d = S_LOCKOUT;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOCKOUT: begin
            if (lt_q == LOCK_LAST) begin
               fail_d  = 3'd0;
               state_d = S_IDLE;
            end else begin
               lt_d = lt_q + LW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
      lockout_d = (state_d == S_LOCKOUT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         prev_q    <= KEY_IDLE;
         cnt_q     <= '0;
         armed_q   <= 1'b0;
         key_out_q <= KEY_IDLE;
         key_stb_q <= 1'b0;
         lockout_q <= 1'b0;
         fail_q    <= 3'd0;
         dig_q     <= 3'd0;
         vt_q      <= '0;
         lt_q      <= '0;
      end else begin
         state_q   <= state_d;
         prev_q    <= prev_d;
         cnt_q     <= cnt_d;
         armed_q   <= armed_d;
         key_out_q <= key_out_d;
         key_stb_q <= key_stb_d;
         lockout_q <= lockout_d;
         fail_q    <= fail_d;
         dig_q     <= dig_d;
         vt_q      <= vt_d;
         lt_q      <= lt_d;
      end
   end

   assign key_out     = key_out_q;
   assign key_stb     = key_stb_q;
   assign lockout     = lockout_q;
   assign fail_count  = fail_q;
   assign digit_count = dig_q;

endmodule

// File: tb/tb_lock_access_controller.sv
// Randomised and directed bench for lock_access_controller against a
// behavioural model built from run lengths and countdowns.
module tb_lock_access_controller;

   localparam int DEB  = 4;
   localparam int VER  = 8;
   localparam int MAXF = 3;
   localparam int LOCK = 20;

   localparam int M_IDLE = 0, M_ENTRY = 1, M_VERIFY = 2, M_CANCEL = 3, M_LOCK = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] key_raw = 4'hF;
   logic       unlocked_in = 1'b0;
   logic [3:0] key_out;
   logic       key_stb;
   logic       lockout;
   logic [2:0] fail_count;
   logic [2:0] digit_count;

   always #5 clk = ~clk;

   lock_access_controller #(
      .DEBOUNCE_CYCLES(DEB),
      .VERIFY_CYCLES  (VER),
      .MAX_FAILS      (MAXF),
      .LOCKOUT_CYCLES (LOCK)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .key_raw    (key_raw),
      .unlocked_in(unlocked_in),
      .key_out    (key_out),
      .key_stb    (key_stb),
      .lockout    (lockout),
      .fail_count (fail_count),
      .digit_count(digit_count)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // Reference model state
   int         m_last, m_run;
   bit         m_armed, m_pend;
   int         m_pcode;
   int         m_mode, m_dig, m_fail, m_vleft, m_lleft;
   int         m_out;
   bit         m_stb;

   // Stimulus/observation state
   int u_mode = 0;  // 0: core never unlocks, 1: unlock 2 cycles into verify, 2: random
   int n_stb, n_cancel, n_lock, n_lkstb, last_code;

   task automatic model_reset();
      m_last = 15; m_run = 0; m_armed = 0; m_pend = 0; m_pcode = 15;
      m_mode = M_IDLE; m_dig = 0; m_fail = 0; m_vleft = 0; m_lleft = 0;
      m_out = 15; m_stb = 0;
   endtask

   task automatic emit(input int code);
      m_out = code;
      m_stb = 1;
   endtask

   task automatic model_edge(input int k, input bit u, input bit r);
      bit ev;
      int code;
      bit dig;
      if (r) begin
         model_reset();
         return;
      end
      ev = m_pend; code = m_pcode;
      dig = (code >= 1 && code <= 9);
      m_out = 15; m_stb = 0;
      case (m_mode)
         M_IDLE: if (ev) begin
            if (dig) begin emit(code); m_dig = 1; m_mode = M_ENTRY; end
            else if (code == 14 || code == 13) emit(code);
         end
         M_ENTRY: if (ev) begin
            if (dig) begin
               emit(code); m_dig++;
               if (m_dig == 4) begin m_mode = M_VERIFY; m_vleft = VER; end
            end else if (code == 13) begin
               emit(code); m_dig = 0; m_mode = M_IDLE;
            end
         end
         M_VERIFY: begin
            if (u) begin m_fail = 0; m_dig = 0; m_mode = M_IDLE; end
            else if (m_vleft == 1) begin
               m_fail = (m_fail + 1 > MAXF) ? MAXF : m_fail + 1;
               m_dig = 0; m_mode = M_CANCEL; emit(13);
            end else m_vleft--;
         end
         M_CANCEL: begin
            if (m_fail == MAXF) begin m_mode = M_LOCK; m_lleft = LOCK; end
            else m_mode = M_IDLE;
         end
         default: begin
            if (m_lleft == 1) begin m_mode = M_IDLE; m_fail = 0; end
            else m_lleft--;
         end
      endcase
      if (k == m_last) m_run++;
      else begin m_last = k; m_run = 1; end
      m_pend = 0;
      if (m_run >= DEB) begin
         if (k == 15) m_armed = 1;
         else if (m_armed) begin m_pend = 1; m_pcode = k; m_armed = 0; end
      end
   endtask

   task automatic step(input logic [3:0] k, input bit r);
      bit u;
      u = 0;
      if (u_mode == 1) u = (m_mode == M_VERIFY && m_vleft == VER - 2);
      else if (u_mode == 2) u = ($urandom_range(5) == 0);
      key_raw = k; unlocked_in = u; rst = r;
      @(posedge clk);
      model_edge(int'(k), u, r);
      #1;
      chk("key_out", key_out, m_out);
      chk("key_stb", key_stb, m_stb);
      chk("lockout", lockout, (m_mode == M_LOCK));
      chk("fail_count", fail_count, m_fail);
      chk("digit_count", digit_count, m_dig);
      if (key_stb) begin
         n_stb++;
         last_code = key_out;
         if (key_out == 4'hD) n_cancel++;
         if (lockout) n_lkstb++;
      end
      if (lockout) n_lock++;
      @(negedge clk);
   endtask

   task automatic press(input logic [3:0] k, input int hold, input int gap);
      repeat (hold) step(k, 0);
      repeat (gap) step(4'hF, 0);
   endtask

   task automatic fail_round();
      press(4'd5, 6, 6); press(4'd6, 6, 6); press(4'd7, 6, 6); press(4'd8, 6, 0);
      repeat (12) step(4'hF, 0);
   endtask

   initial begin
      int sel, hold, gap;
      logic [3:0] code;
      model_reset();
      n_stb = 0; n_cancel = 0; n_lock = 0; n_lkstb = 0; last_code = 0;
      @(negedge clk);

      step(4'hF, 1);
      chk("rst_key_out", key_out, 4'hF);
      chk("rst_key_stb", key_stb, 0);
      chk("rst_lockout", lockout, 0);
      chk("rst_fail", fail_count, 0);
      chk("rst_digit", digit_count, 0);
      step(4'hF, 1);
      repeat (6) step(4'hF, 0);

      n_stb = 0; press(4'd3, 10, 6);
      chk("p3_stb", n_stb, 1); chk("p3_code", last_code, 3); chk("p3_dig", digit_count, 1);

      n_stb = 0;
      repeat (5) begin repeat (2) step(4'd3, 0); repeat (2) step(4'hF, 0); end
      chk("bounce_stb", n_stb, 0);
      press(4'd3, 10, 6);
      chk("clean_stb", n_stb, 1); chk("clean_dig", digit_count, 2);

      n_cancel = 0; press(4'hD, 8, 6);
      chk("ucancel_n", n_cancel, 1); chk("ucancel_dig", digit_count, 0);
      chk("ucancel_fail", fail_count, 0);

      u_mode = 1; n_stb = 0; n_cancel = 0;
      press(4'd1, 6, 6); press(4'd2, 6, 6); press(4'd3, 6, 6); press(4'd4, 6, 0);
      repeat (12) step(4'hF, 0);
      chk("ok_stb", n_stb, 4); chk("ok_cancel", n_cancel, 0);
      chk("ok_fail", fail_count, 0); chk("ok_dig", digit_count, 0);
      n_stb = 0; press(4'hE, 6, 6);
      chk("set_stb", n_stb, 1); chk("set_code", last_code, 14);
      u_mode = 0;

      n_cancel = 0; fail_round();
      chk("f1_cancel", n_cancel, 1); chk("f1_fail", fail_count, 1);
      press(4'd2, 6, 6); press(4'd2, 6, 6);
      chk("c2_dig", digit_count, 2);
      press(4'hD, 6, 6);
      chk("c2_cancel", n_cancel, 2); chk("c2_dig0", digit_count, 0);
      chk("c2_fail", fail_count, 1);

      n_cancel = 0; n_lock = 0; n_lkstb = 0;
      fail_round(); chk("f2_fail", fail_count, 2);
      fail_round();
      press(4'd9, 6, 4);
      repeat (10) step(4'hF, 0);
      chk("lk_cycles", n_lock, LOCK); chk("lk_stb", n_lkstb, 0);
      chk("lk_cancel", n_cancel, 2); chk("lk_fail", fail_count, 0);
      chk("lk_out", lockout, 0);

      press(4'd1, 6, 6); press(4'd2, 6, 6); press(4'd3, 6, 6);
      repeat (7) step(4'd4, 0);
      step(4'd4, 1);
      chk("rv_dig", digit_count, 0); chk("rv_stb", key_stb, 0);
      chk("rv_key_out", key_out, 4'hF);
      repeat (6) step(4'hF, 0);
      n_stb = 0; press(4'd2, 8, 6);
      chk("rv_next_stb", n_stb, 1); chk("rv_next_code", last_code, 2);

      fail_round(); fail_round(); fail_round();
      repeat (3) step(4'hF, 0);
      chk("rl_mid", lockout, 1);
      step(4'hF, 1);
      chk("rl_lockout", lockout, 0); chk("rl_fail", fail_count, 0);
      chk("rl_dig", digit_count, 0);
      repeat (6) step(4'hF, 0);
      n_stb = 0; press(4'd7, 8, 6);
      chk("rl_next_stb", n_stb, 1); chk("rl_next_code", last_code, 7);

      u_mode = 2;
      repeat (400) begin
         sel  = $urandom_range(9);
         hold = $urandom_range(8, 1);
         gap  = $urandom_range(8, 1);
         if (sel <= 5) code = 4'($urandom_range(9, 1));
         else if (sel == 6) code = 4'hD;
         else if (sel == 7) code = 4'($urandom_range(12, 10));
         else code = 4'hF;
         if (sel == 8) begin
            repeat (hold) begin step(4'($urandom_range(9, 1)), 0); step(4'hF, 0); end
         end else begin
            press(code, hold, gap);
         end
         if ($urandom_range(199) == 0) step(4'hF, 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
